// File: rtl/xheep_run_ctrl.sv
// Host-side run controller for x_heep_system: sequences reset, boot straps and JTAG reset,
// then waits for the exit handshake and records status, exit value and run length.
module xheep_run_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        boot_select_cfg_i,
  input  logic        exec_flash_cfg_i,
  input  logic [31:0] timeout_cycles_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  status_o,
  output logic [31:0] exit_value_q_o,
  output logic [31:0] run_cycles_o,
  output logic        xheep_rst_no,
  output logic        jtag_trst_no,
  output logic        boot_select_o,
  output logic        execute_from_flash_o,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RELEASE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [1:0] ST_PASS    = 2'b00;
  localparam logic [1:0] ST_FAIL    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_ABORT   = 2'b11;

  state_t                 state;
  logic [31:0]            cnt;
  logic [SYNC_STAGES-1:0] sync_p;
  logic                   exit_valid_s;
  logic                   active;
  logic                   timeout_hit;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // exit_valid_i comes from another timing domain: plain flop chain, oldest bit used
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_p <= '0;
    else       sync_p <= {sync_p[SYNC_STAGES-2:0], exit_valid_i};
  end

  assign exit_valid_s = sync_p[SYNC_STAGES-1];
  assign active       = (state == S_RESET) || (state == S_RELEASE) || (state == S_RUN);
  assign timeout_hit  = (timeout_cycles_i != 32'd0) &&
                        (run_cycles_o == timeout_cycles_i - 32'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state                <= S_IDLE;
      cnt                  <= '0;
      busy_o               <= 1'b0;
      done_o               <= 1'b0;
      status_o             <= ST_PASS;
      exit_value_q_o       <= '0;
      run_cycles_o         <= '0;
      xheep_rst_no         <= 1'b0;
      jtag_trst_no         <= 1'b0;
      boot_select_o        <= 1'b0;
      execute_from_flash_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      // Abort outranks exit and timeout, and leaves the core parked in reset
      if (abort_i && active) begin
        xheep_rst_no <= 1'b0;
        jtag_trst_no <= 1'b0;
        status_o     <= ST_ABORT;
        busy_o       <= 1'b0;
        done_o       <= 1'b1;
        state        <= S_DONE;
        if (state == S_RUN) run_cycles_o <= sat_inc(run_cycles_o);
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i && !abort_i) begin
              boot_select_o        <= boot_select_cfg_i;
              execute_from_flash_o <= exec_flash_cfg_i;
              run_cycles_o         <= '0;
              cnt                  <= '0;
              xheep_rst_no         <= 1'b0;
              jtag_trst_no         <= 1'b0;
              busy_o               <= 1'b1;
              state                <= S_RESET;
            end
          end
          S_RESET: begin
            if (cnt == RST_CYCLES - 1) begin
              cnt          <= '0;
              xheep_rst_no <= 1'b1;
              state        <= S_RELEASE;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          S_RELEASE: begin
            if (cnt == SETTLE_CYCLES - 1) begin
              cnt          <= '0;
              jtag_trst_no <= 1'b1;
              state        <= S_RUN;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          S_RUN: begin
            run_cycles_o <= sat_inc(run_cycles_o);
            if (exit_valid_s) begin
              exit_value_q_o <= exit_value_i;
              status_o       <= (exit_value_i == 32'd0) ? ST_PASS : ST_FAIL;
              busy_o         <= 1'b0;
              done_o         <= 1'b1;
              state          <= S_DONE;
            end else if (timeout_hit) begin
              status_o <= ST_TIMEOUT;
              busy_o   <= 1'b0;
              done_o   <= 1'b1;
              state    <= S_DONE;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xheep_run_ctrl.sv
// Directed and randomized runs of xheep_run_ctrl checked against an event-order model.
module tb_xheep_run_ctrl;

  localparam int RST_CYCLES    = 16;
  localparam int SETTLE_CYCLES = 4;
  localparam int SYNC_STAGES   = 2;
  localparam int INF           = 1 << 30;
  localparam int LIMIT         = 600;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        abort_i;
  logic        boot_select_cfg_i;
  logic        exec_flash_cfg_i;
  logic [31:0] timeout_cycles_i;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  status_o;
  logic [31:0] exit_value_q_o;
  logic [31:0] run_cycles_o;
  logic        xheep_rst_no;
  logic        jtag_trst_no;
  logic        boot_select_o;
  logic        execute_from_flash_o;
  logic        exit_valid_i;
  logic [31:0] exit_value_i;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_exit = 32'd0;

  always #5 clk_i = ~clk_i;

  xheep_run_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .SYNC_STAGES  (SYNC_STAGES)
  ) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .start_i             (start_i),
    .abort_i             (abort_i),
    .boot_select_cfg_i   (boot_select_cfg_i),
    .exec_flash_cfg_i    (exec_flash_cfg_i),
    .timeout_cycles_i    (timeout_cycles_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .status_o            (status_o),
    .exit_value_q_o      (exit_value_q_o),
    .run_cycles_o        (run_cycles_o),
    .xheep_rst_no        (xheep_rst_no),
    .jtag_trst_no        (jtag_trst_no),
    .boot_select_o       (boot_select_o),
    .execute_from_flash_o(execute_from_flash_o),
    .exit_valid_i        (exit_valid_i),
    .exit_value_i        (exit_value_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Which event ends the run, counted in RUN cycles (0 = first cycle with jtag released)
  function automatic void model(input int v, input int tmo, input int ab, input logic [31:0] val,
                                output int det, output logic [1:0] st);
    int dv, dt, da;
    dv = (v >= 0) ? v + SYNC_STAGES : INF;
    dt = (tmo != 0) ? tmo - 1 : INF;
    da = (ab >= 0) ? ab : INF;
    if (da <= dv && da <= dt) begin det = da; st = 2'b11; end
    else if (dv <= dt)        begin det = dv; st = (val == 0) ? 2'b00 : 2'b01; end
    else                      begin det = dt; st = 2'b10; end
  endfunction

  // v: RUN cycle before which exit_valid_i rises (-1 none); ab: RUN cycle of abort (-1 none)
  task automatic do_run(input string tag, input logic boot, input logic flash, input int tmo,
                        input int v, input logic [31:0] val, input int ab, input int busy_start);
    int lo, st_n, k, det, extra;
    logic got;
    logic [1:0] exp_st;
    model(v, tmo, ab, val, det, exp_st);
    boot_select_cfg_i = boot;
    exec_flash_cfg_i  = flash;
    timeout_cycles_i  = tmo;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk({tag, "_busy"}, busy_o, 1);
    chk({tag, "_boot"}, boot_select_o, boot);
    chk({tag, "_flash"}, execute_from_flash_o, flash);
    chk({tag, "_rc_clr"}, run_cycles_o, 0);
    lo = 0;
    while (xheep_rst_no == 1'b0 && lo < LIMIT) begin lo++; @(negedge clk_i); end
    chk({tag, "_rst_low"}, lo, RST_CYCLES);
    st_n = 0;
    while (jtag_trst_no == 1'b0 && st_n < LIMIT) begin st_n++; @(negedge clk_i); end
    chk({tag, "_settle"}, st_n, SETTLE_CYCLES);
    k = 0;
    got = 1'b0;
    while (!got && k < LIMIT) begin
      if (k == v) begin exit_valid_i = 1'b1; exit_value_i = val; end
      abort_i = (k == ab);
      start_i = (k == busy_start);
      @(negedge clk_i);
      abort_i = 1'b0;
      start_i = 1'b0;
      k++;
      if (done_o) got = 1'b1;
    end
    chk({tag, "_done"}, got, 1);
    chk({tag, "_latency"}, k, det + 1);
    chk({tag, "_status"}, status_o, exp_st);
    chk({tag, "_busy_done"}, busy_o, 0);
    if (exp_st == 2'b00 || exp_st == 2'b01) last_exit = val;
    chk({tag, "_exit"}, exit_value_q_o, last_exit);
    if (exp_st != 2'b11) chk({tag, "_rc"}, run_cycles_o, det + 1);
    chk({tag, "_xrst"}, xheep_rst_no, (exp_st == 2'b11) ? 0 : 1);
    exit_valid_i = 1'b0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (done_o || busy_o) extra++;
    end
    chk({tag, "_quiet"}, extra, 0);
    chk({tag, "_status_hold"}, status_o, exp_st);
  endtask

  initial begin
    int extra;
    int v, tmo, ab;
    logic [31:0] val;
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    boot_select_cfg_i = 1'b0; exec_flash_cfg_i = 1'b0; timeout_cycles_i = 32'd0;
    exit_valid_i = 1'b0; exit_value_i = 32'd0;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_xrst", xheep_rst_no, 0);
    chk("rst_jtag", jtag_trst_no, 0);
    chk("rst_status", status_o, 0);
    chk("rst_rc", run_cycles_o, 0);
    chk("rst_boot", boot_select_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    do_run("pass0", 1'b1, 1'b0, 0, 97, 32'd0, -1, -1);
    do_run("fail5", 1'b0, 1'b1, 0, 20, 32'h0000_0005, -1, -1);
    do_run("tmo50", 1'b1, 1'b1, 50, -1, 32'd0, -1, -1);
    do_run("tmo_vld", 1'b0, 1'b0, 50, 50 - 1 - SYNC_STAGES, 32'h0000_00A7, -1, -1);
    do_run("tmo1", 1'b0, 1'b0, 1, -1, 32'd0, -1, -1);
    do_run("busy_st", 1'b1, 1'b0, 0, 15, 32'd0, -1, 5);
    do_run("abort", 1'b1, 1'b1, 0, 40, 32'h0000_0009, 30, -1);

    // Start and abort together in IDLE must do nothing
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; abort_i = 1'b0;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy_o || done_o || xheep_rst_no) extra++;
      @(negedge clk_i);
    end
    chk("st_ab_idle", extra, 0);
    chk("st_ab_boot", boot_select_o, 1);

    for (int r = 0; r < 6; r++) begin
      v   = $urandom_range(0, 60);
      tmo = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 70);
      ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 50) : -1;
      val = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
      do_run($sformatf("rnd%0d", r), 1'($urandom), 1'($urandom), tmo, v, val, ab, -1);
    end

    // Asynchronous reset in the middle of RUN
    timeout_cycles_i = 32'd0;
    boot_select_cfg_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    extra = 0;
    while (jtag_trst_no == 1'b0 && extra < LIMIT) begin extra++; @(negedge clk_i); end
    chk("mid_inrun", jtag_trst_no, 1);
    repeat (10) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("mid_busy", busy_o, 0);
    chk("mid_xrst", xheep_rst_no, 0);
    chk("mid_jtag", jtag_trst_no, 0);
    chk("mid_boot", boot_select_o, 0);
    chk("mid_rc", run_cycles_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (busy_o || done_o) extra++;
    end
    chk("mid_idle", extra, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
